// File: rtl/commit_trace_buffer.sv
// Retirement-trace capture buffer: records committed instructions in linear or
// circular mode, with an optional PC-match trigger and post-trigger window.
module commit_trace_buffer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4,
    parameter int unsigned DROP_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit_valid,
    input  logic [WIDTH-1:0]           commit_pc,
    input  logic [31:0]                commit_instr,
    input  logic [4:0]                 commit_rd,
    input  logic                       commit_we,
    input  logic [WIDTH-1:0]           commit_wdata,
    input  logic                       arm,
    input  logic                       mode,
    input  logic                       trig_en,
    input  logic [WIDTH-1:0]           trig_pc,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [2*WIDTH+37:0]        rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 state_o,
    output logic                       triggered,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = (AW < 1) ? 1 : AW;
    localparam int unsigned EW = 2 * WIDTH + 38;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_POST    = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    state_t            r_state;
    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_post_left;
    logic              r_mode;
    logic              r_trig_en;
    logic [WIDTH-1:0]  r_trig_pc;
    logic              r_triggered;
    logic [DROP_W-1:0] r_drop_cnt;

    logic [EW-1:0]     w_entry;
    logic              w_store;
    logic              w_full;
    logic              w_hit;
    logic              w_lin_last;
    logic [DROP_W-1:0] w_drop_next;

    assign w_entry     = {commit_pc, commit_instr, commit_rd, commit_we, commit_wdata};
    assign w_store     = commit_valid && ((r_state == S_CAPTURE) || (r_state == S_POST));
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_hit       = r_trig_en && (commit_pc == r_trig_pc) && (r_state == S_CAPTURE);
    // Linear mode: this commit fills the last free slot.
    assign w_lin_last  = !r_mode && (r_count == CW'(DEPTH - 1));
    assign w_drop_next = (r_drop_cnt == '1) ? r_drop_cnt : r_drop_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst && !arm && w_store) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post_left <= '0;
            r_mode      <= 1'b0;
            r_trig_en   <= 1'b0;
            r_trig_pc   <= '0;
            r_triggered <= 1'b0;
            r_drop_cnt  <= '0;
        end else if (arm) begin
            r_state     <= S_CAPTURE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post_left <= '0;
            r_mode      <= mode;
            r_trig_en   <= trig_en;
            r_trig_pc   <= trig_pc;
            r_triggered <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                end
                S_CAPTURE, S_POST: begin
                    if (commit_valid) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        // Full is only reachable in circular mode: overwrite the oldest.
                        if (w_full) begin
                            r_rd_ptr   <= r_rd_ptr + 1'b1;
                            r_drop_cnt <= w_drop_next;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                        if (w_hit) begin
                            r_triggered <= 1'b1;
                        end
                        if (w_lin_last) begin
                            r_state <= S_DONE;
                        end else if (r_state == S_POST) begin
                            r_post_left <= r_post_left - 1'b1;
                            if (r_post_left == PW'(1)) begin
                                r_state <= S_DONE;
                            end
                        end else if (w_hit) begin
                            if (POST_TRIG == 0) begin
                                r_state <= S_DONE;
                            end else begin
                                r_state     <= S_POST;
                                r_post_left <= PW'(POST_TRIG);
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (commit_valid) begin
                        r_drop_cnt <= w_drop_next;
                    end
                    if (r_count == '0) begin
                        r_state <= S_IDLE;
                    end else if (rd_ready) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_count  <= r_count - 1'b1;
                        if (r_count == CW'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_valid  = (r_state == S_DONE) && (r_count != '0);
    assign rd_data   = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign state_o   = r_state;
    assign triggered = r_triggered;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_commit_trace_buffer;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned POST_TRIG = 4;
    localparam int unsigned DROP_W    = 16;
    localparam int unsigned EW        = 2 * WIDTH + 38;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              commit_valid;
    logic [WIDTH-1:0]  commit_pc;
    logic [31:0]       commit_instr;
    logic [4:0]        commit_rd;
    logic              commit_we;
    logic [WIDTH-1:0]  commit_wdata;
    logic              arm;
    logic              mode;
    logic              trig_en;
    logic [WIDTH-1:0]  trig_pc;
    logic              rd_valid;
    logic              rd_ready;
    logic [EW-1:0]     rd_data;
    logic [CW-1:0]     count;
    logic [1:0]        state_o;
    logic              triggered;
    logic [DROP_W-1:0] drop_cnt;

    commit_trace_buffer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .commit_rd(commit_rd), .commit_we(commit_we), .commit_wdata(commit_wdata),
        .arm(arm), .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count), .state_o(state_o), .triggered(triggered), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a FIFO of captured entries plus phase bookkeeping.
    logic [EW-1:0]    m_q[$];
    int               m_phase;      // 0 idle, 1 capture, 2 post, 3 done
    int               m_left;
    bit               m_mode;
    bit               m_ten;
    logic [WIDTH-1:0] m_tpc;
    bit               m_trig;
    int unsigned      m_drop;

    function automatic void bump_drop();
        if (m_drop < (32'd1 << DROP_W) - 1) m_drop++;
    endfunction

    function automatic void model_step();
        bit hit;
        if (rst) begin
            m_q.delete(); m_phase = 0; m_trig = 0; m_drop = 0; m_mode = 0; m_ten = 0; m_tpc = '0;
        end else if (arm) begin
            m_q.delete(); m_phase = 1; m_trig = 0; m_drop = 0;
            m_mode = mode; m_ten = trig_en; m_tpc = trig_pc;
        end else if ((m_phase == 1 || m_phase == 2) && commit_valid) begin
            hit = (m_phase == 1) && m_ten && (commit_pc == m_tpc);
            if (m_q.size() == DEPTH) begin
                void'(m_q.pop_front());
                bump_drop();
            end
            m_q.push_back({commit_pc, commit_instr, commit_rd, commit_we, commit_wdata});
            if (hit) m_trig = 1;
            if (!m_mode && m_q.size() == DEPTH) m_phase = 3;
            else if (m_phase == 2) begin
                m_left--;
                if (m_left == 0) m_phase = 3;
            end else if (hit) begin
                if (POST_TRIG == 0) m_phase = 3;
                else begin m_phase = 2; m_left = POST_TRIG; end
            end
        end else if (m_phase == 3) begin
            if (commit_valid) bump_drop();
            if (m_q.size() == 0) m_phase = 0;
            else if (rd_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_phase = 0;
            end
        end
    endfunction

    task automatic compare_all();
        bit ev;
        ev = (m_phase == 3) && (m_q.size() != 0);
        chk("state", state_o, m_phase);
        chk("count", count, m_q.size());
        chk("rd_valid", rd_valid, ev);
        chk("triggered", triggered, m_trig);
        chk("drop_cnt", drop_cnt, m_drop);
        if (ev) chk("rd_data", rd_data, m_q[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_commit(input bit v, input logic [WIDTH-1:0] pc);
        commit_valid = v;
        commit_pc    = pc;
        commit_instr = $urandom;
        commit_rd    = 5'($urandom);
        commit_we    = 1'($urandom);
        commit_wdata = $urandom;
    endtask

    task automatic commit(input logic [WIDTH-1:0] pc);
        set_commit(1'b1, pc);
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic do_arm(input bit md, input bit te, input logic [WIDTH-1:0] tp);
        arm = 1'b1; mode = md; trig_en = te; trig_pc = tp;
        tick();
        arm = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] pc_of(input logic [EW-1:0] e);
        return e[EW-1 -: WIDTH];
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [EW-1:0] held;
        rst = 1'b1; arm = 1'b0; mode = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
        set_commit(1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_state", state_o, 0);
        chk("rst_rd_valid", rd_valid, 0);

        // Linear fill: 20 commits, 16 stored, 4 dropped after DONE.
        do_arm(1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            commit(WIDTH'(4 * i));
            if (i == 15) chk("lin_done", state_o, 3);
        end
        chk("lin_count", count, 16);
        chk("lin_drop", drop_cnt, 4);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("lin_pc", pc_of(rd_data), 4 * i);
            tick();
        end
        rd_ready = 1'b0;
        chk("lin_idle", state_o, 0);

        // Circular with trigger at 0x40 and a 4-entry post window.
        do_arm(1'b1, 1'b1, 32'h40);
        for (int i = 0; i < 30; i++) begin
            commit(WIDTH'(4 * i));
            if (i == 20) chk("circ_done", state_o, 3);
        end
        chk("circ_trig", triggered, 1);
        chk("circ_drop", drop_cnt, 14);
        chk("circ_count", count, 16);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("circ_pc", pc_of(rd_data), 32'h14 + 4 * i);
            tick();
        end
        rd_ready = 1'b0;

        // Backpressure readout.
        do_arm(1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) commit(WIDTH'(32'h1000 + 4 * i));
        for (int k = 0; k < 64 && state_o != 2'd0; k++) begin
            rd_ready = k[0];
            held = rd_data;
            tick();
            if (!k[0] && state_o == 2'd3) chk("bp_stable", rd_data, held);
        end
        rd_ready = 1'b0;
        chk("bp_idle", state_o, 0);

        // arm coincident with a commit.
        set_commit(1'b1, 32'h100);
        do_arm(1'b0, 1'b0, '0);
        commit_valid = 1'b0;
        chk("arm_commit_cnt", count, 0);
        commit(32'h200);
        chk("arm_next_cnt", count, 1);
        for (int i = 1; i < 16; i++) commit(WIDTH'(32'h200 + 4 * i));
        chk("arm_entry0", pc_of(rd_data), 32'h200);

        // arm during DONE with 7 unread entries.
        rd_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        rd_ready = 1'b0;
        chk("done7_count", count, 7);
        do_arm(1'b0, 1'b0, '0);
        chk("rearm_state", state_o, 1);
        chk("rearm_count", count, 0);
        chk("rearm_drop", drop_cnt, 0);
        for (int i = 0; i < 16; i++) commit(WIDTH'(32'h300 + 4 * i));
        chk("rearm_first", pc_of(rd_data), 32'h300);

        // rst in the middle of the post-trigger window.
        do_arm(1'b1, 1'b1, 32'h40);
        commit(32'h3C);
        commit(32'h40);
        commit(32'h44);
        chk("post_state", state_o, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_state", state_o, 0);
        chk("post_rst_count", count, 0);
        chk("post_rst_valid", rd_valid, 0);
        chk("post_rst_trig", triggered, 0);
        chk("post_rst_drop", drop_cnt, 0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            arm = ($urandom_range(0, 49) == 0);
            mode = 1'($urandom);
            trig_en = ($urandom_range(0, 3) != 0);
            trig_pc = WIDTH'(4 * $urandom_range(0, 23));
            set_commit($urandom_range(0, 9) < 6, WIDTH'(4 * $urandom_range(0, 23)));
            rd_ready = 1'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
